// File: rtl/pe_cmd_master_pkg.sv
// pe_cmd_pkg: PE register map, trigger value and FSM encoding shared by pe_cmd_master.
// PE_CMD_MASTER_READ_EN adds the read-channel states to the encoding.
package pe_cmd_pkg;

   localparam logic [2:0]  PE_REG_ADDR = 3'd0;
   localparam logic [2:0]  PE_REG_D0   = 3'd1;
   localparam logic [2:0]  PE_REG_D1   = 3'd2;
   localparam logic [2:0]  PE_REG_D2   = 3'd3;
   localparam logic [2:0]  PE_REG_D3   = 3'd4;
   localparam logic [2:0]  PE_REG_TRIG = 3'd5;
   localparam logic [31:0] PE_TRIG_VAL = 32'h1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ASSERT,
      S_WR_GAP
`ifdef PE_CMD_MASTER_READ_EN
      ,
      S_RD_ASSERT,
      S_RD_WAIT,
      S_RD_DONE
`endif
   } state_e;

endpackage

// File: rtl/pe_cmd_master_if.sv
// pe_cmd_master_if: host command/read handshakes and PE bus strobes around pe_cmd_master.
// master is the initiator's view; slave is the host plus PE_wrapper side.
interface pe_cmd_master_if #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 5
);

   logic                   iCmdValid;
   logic                   oCmdReady;
   logic [AddrWidth-1:0]   iCmdAddr;
   logic [4*DataWidth-1:0] iCmdData;
   logic                   iRdValid;
   logic                   oRdReady;
   logic [3:0]             iRdAddr;
   logic                   oRdValid;
   logic [DataWidth-1:0]   oRdData;
   logic                   oBusy;
   logic                   oChipSelect_n;
   logic                   oWrite_n;
   logic                   oRead_n;
   logic [31:0]            oAddress;
   logic [DataWidth-1:0]   oData;
   logic [DataWidth-1:0]   iBusData;

   modport master (
      input  iCmdValid, iCmdAddr, iCmdData, iRdValid, iRdAddr, iBusData,
      output oCmdReady, oRdReady, oRdValid, oRdData, oBusy,
             oChipSelect_n, oWrite_n, oRead_n, oAddress, oData
   );

   modport slave (
      output iCmdValid, iCmdAddr, iCmdData, iRdValid, iRdAddr, iBusData,
      input  oCmdReady, oRdReady, oRdValid, oRdData, oBusy,
             oChipSelect_n, oWrite_n, oRead_n, oAddress, oData
   );

endinterface

// File: rtl/pe_cmd_master.sv
// pe_cmd_master: turns one instruction command into the six-register PE write sequence.
// Define PE_CMD_MASTER_READ_EN to compile in the single-register read channel.
module pe_cmd_master
   import pe_cmd_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 5
) (
   input logic             iClk,
   input logic             iReset_n,
   pe_cmd_master_if.master bus
);

   state_e                 state_q, state_d;
   logic [2:0]             idx_q, idx_d;
   logic [AddrWidth-1:0]   cmd_addr_q, cmd_addr_d;
   logic [4*DataWidth-1:0] cmd_data_q, cmd_data_d;
   logic                   rdy_q;
   logic                   cs_n_q, cs_n_d;
   logic                   wr_n_q, wr_n_d;
   logic [31:0]            addr_q, addr_d;
   logic [DataWidth-1:0]   data_q, data_d, word_d;
   logic                   cmd_hs;

`ifdef PE_CMD_MASTER_READ_EN
   logic                   rd_hs;
   logic                   rd_n_q, rd_n_d;
   logic                   rd_valid_q;
   logic [3:0]             rd_addr_q, rd_addr_d;
   logic [DataWidth-1:0]   rd_data_q;

   // A simultaneous write command wins, so the read is only taken when no command is offered.
   assign rd_hs = bus.iRdValid & rdy_q & ~bus.iCmdValid;
`else
   logic unused_rd;

   assign unused_rd = ^{bus.iRdValid, bus.iRdAddr, bus.iBusData};
`endif

   assign cmd_hs = bus.iCmdValid & rdy_q;

   always_ff @(posedge iClk or negedge iReset_n)
      if (!iReset_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cmd_addr_q <= '0;
         cmd_data_q <= '0;
         rdy_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         addr_q     <= '0;
         data_q     <= '0;
`ifdef PE_CMD_MASTER_READ_EN
         rd_n_q     <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cmd_addr_q <= cmd_addr_d;
         cmd_data_q <= cmd_data_d;
         rdy_q      <= state_d == S_IDLE;
         cs_n_q     <= cs_n_d;
         wr_n_q     <= wr_n_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
`ifdef PE_CMD_MASTER_READ_EN
         rd_n_q     <= rd_n_d;
         rd_valid_q <= state_d == S_RD_DONE;
         rd_addr_q  <= rd_addr_d;
         rd_data_q  <= state_q == S_RD_WAIT ? bus.iBusData : rd_data_q;
`endif
      end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cmd_addr_d = cmd_addr_q;
      cmd_data_d = cmd_data_q;
`ifdef PE_CMD_MASTER_READ_EN
      rd_addr_d  = rd_addr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_hs) begin
               cmd_addr_d = bus.iCmdAddr;
               cmd_data_d = bus.iCmdData;
               idx_d      = PE_REG_ADDR;
               state_d    = S_WR_ASSERT;
            end
`ifdef PE_CMD_MASTER_READ_EN
            else if (rd_hs) begin
               rd_addr_d = bus.iRdAddr;
               state_d   = S_RD_ASSERT;
            end
`endif
         end
         S_WR_ASSERT: state_d = S_WR_GAP;
         S_WR_GAP: begin
            state_d = idx_q == PE_REG_TRIG ? S_IDLE : S_WR_ASSERT;
            idx_d   = idx_q == PE_REG_TRIG ? idx_q : idx_q + 3'd1;
         end
`ifdef PE_CMD_MASTER_READ_EN
         S_RD_ASSERT: state_d = S_RD_WAIT;
         S_RD_WAIT:   state_d = S_RD_DONE;
         S_RD_DONE:   state_d = S_IDLE;
`endif
         default:     state_d = S_IDLE;
      endcase
   end

   // Outputs are computed from the next state so every strobe leaves a flop.
   always_comb begin
      word_d = idx_d == PE_REG_ADDR ? DataWidth'(cmd_addr_d) :
               idx_d == PE_REG_D0   ? cmd_data_d[4*DataWidth-1 -: DataWidth] :
               idx_d == PE_REG_D1   ? cmd_data_d[3*DataWidth-1 -: DataWidth] :
               idx_d == PE_REG_D2   ? cmd_data_d[2*DataWidth-1 -: DataWidth] :
               idx_d == PE_REG_D3   ? cmd_data_d[DataWidth-1 -: DataWidth] :
                                      DataWidth'(PE_TRIG_VAL);
      wr_n_d = state_d != S_WR_ASSERT;
      data_d = wr_n_d ? data_q : word_d;
`ifdef PE_CMD_MASTER_READ_EN
      rd_n_d = state_d != S_RD_ASSERT;
      cs_n_d = wr_n_d & rd_n_d;
      addr_d = !wr_n_d ? 32'(idx_d) : !rd_n_d ? 32'(rd_addr_d) : addr_q;
`else
      cs_n_d = wr_n_d;
      addr_d = !wr_n_d ? 32'(idx_d) : addr_q;
`endif
   end

   assign bus.oCmdReady     = rdy_q;
   assign bus.oBusy         = state_q != S_IDLE;
   assign bus.oChipSelect_n = cs_n_q;
   assign bus.oWrite_n      = wr_n_q;
   assign bus.oAddress      = addr_q;
   assign bus.oData         = data_q;

`ifdef PE_CMD_MASTER_READ_EN
   assign bus.oRdReady      = rdy_q & ~bus.iCmdValid;
   assign bus.oRdValid      = rd_valid_q;
   assign bus.oRdData       = rd_data_q;
   assign bus.oRead_n       = rd_n_q;
`else
   assign bus.oRdReady      = 1'b0;
   assign bus.oRdValid      = 1'b0;
   assign bus.oRdData       = '0;
   assign bus.oRead_n       = 1'b1;
`endif

endmodule

// File: tb/tb_pe_cmd_master.sv
// tb_pe_cmd_master: directed vector table, corner sequences and random traffic
// checked cycle by cycle against a schedule-based model of the PE bus.
module tb_pe_cmd_master;

`ifdef PE_CMD_MASTER_READ_EN
   localparam bit RD_EN = 1'b1;
`else
   localparam bit RD_EN = 1'b0;
`endif

   logic iClk = 1'b0;
   logic iReset_n = 1'b0;

   pe_cmd_master_if bus ();

   pe_cmd_master dut (
      .iClk    (iClk),
      .iReset_n(iReset_n),
      .bus     (bus)
   );

   always #5 iClk = ~iClk;

   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   ev_t wlog[$];
   ev_t rlog[$];
   ev_t vlog[$];

   function automatic int first_cyc(input ev_t q[$], input int i0);
      return q.size() > i0 ? q[i0].cyc : -1;
   endfunction

   // Reference model: each accepted transaction books its future bus events by cycle number.
   logic [31:0] ew_a[int];
   logic [31:0] ew_d[int];
   int          rs_cyc = -1, cap_cyc = -1, rv_cyc = -1;
   logic [31:0] rd_a = '0, cap_val = '0;
   logic [31:0] m_addr = '0, m_data = '0, m_rd = '0;
   int          free_at = 1 << 30;
   int          busy_end = 0;
   bit          in_rst = 1'b1;
   bit          ew, er, ev, rdy;

   always @(negedge iClk) begin
      if (!iReset_n) begin
         ew_a.delete();
         ew_d.delete();
         rs_cyc = -1;
         cap_cyc = -1;
         rv_cyc = -1;
         m_addr = '0;
         m_data = '0;
         m_rd = '0;
         busy_end = 0;
         in_rst = 1'b1;
      end else if (in_rst) begin
         in_rst = 1'b0;
         free_at = cyc + 1;
      end
      ew = iReset_n && ew_a.exists(cyc);
      er = iReset_n && rs_cyc == cyc;
      ev = iReset_n && rv_cyc == cyc;
      if (ew) begin
         m_addr = ew_a[cyc];
         m_data = ew_d[cyc];
      end
      if (er) m_addr = rd_a;
      if (iReset_n && cap_cyc == cyc) cap_val = bus.iBusData;
      if (ev) m_rd = cap_val;
      rdy = iReset_n && cyc >= free_at;
      chk("cs_n", bus.oChipSelect_n, !(ew || er));
      chk("wr_n", bus.oWrite_n, !ew);
      chk("rd_n", bus.oRead_n, !er);
      chk("wr_rd_overlap", !bus.oWrite_n && !bus.oRead_n, 1'b0);
      chk("address", bus.oAddress, m_addr);
      chk("wdata", bus.oData, m_data);
      chk("rd_valid", bus.oRdValid, ev);
      chk("rd_data", bus.oRdData, m_rd);
      chk("busy", bus.oBusy, iReset_n && cyc < busy_end);
      chk("cmd_ready", bus.oCmdReady, rdy);
      chk("rd_ready", bus.oRdReady, RD_EN && rdy && !bus.iCmdValid);
      if (!bus.oWrite_n) wlog.push_back('{cyc, bus.oAddress, bus.oData});
      if (!bus.oRead_n) rlog.push_back('{cyc, bus.oAddress, 32'h0});
      if (bus.oRdValid) vlog.push_back('{cyc, 32'h0, bus.oRdData});
      if (rdy && bus.iCmdValid) begin
         for (int k = 0; k < 6; k++) begin
            ew_a[cyc + 1 + 2 * k] = k;
            ew_d[cyc + 1 + 2 * k] = k == 0 ? 32'(bus.iCmdAddr) :
                                    k == 5 ? 32'h1 : 32'(bus.iCmdData >> (32 * (4 - k)));
         end
         free_at = cyc + 13;
         busy_end = cyc + 13;
      end else if (RD_EN && rdy && bus.iRdValid) begin
         rs_cyc = cyc + 1;
         rd_a = 32'(bus.iRdAddr);
         cap_cyc = cyc + 2;
         rv_cyc = cyc + 3;
         free_at = cyc + 4;
         busy_end = cyc + 4;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge iClk);
      #1;
   endtask

   typedef struct {
      logic [4:0]       addr;
      logic [127:0]     data;
      logic [5:0][31:0] exp;
   } vec_t;

   vec_t tbl[4];
   ev_t  e;
   int   c, i0, r0, v0;

   initial begin
      tbl[0] = '{5'd0, 128'hDEADBEEF_CAFEBABE_12345678_87654321,
                 {32'h1, 32'h87654321, 32'h12345678, 32'hCAFEBABE, 32'hDEADBEEF, 32'h0}};
      tbl[1] = '{5'd1, 128'h11111111_22222222_33333333_44444444,
                 {32'h1, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h1}};
      tbl[2] = '{5'd31, 128'hFFFFFFFF_00000000_80000001_7FFFFFFE,
                 {32'h1, 32'h7FFFFFFE, 32'h80000001, 32'h00000000, 32'hFFFFFFFF, 32'h1F}};
      tbl[3] = '{5'd16, 128'h0, {32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h10}};
      bus.iCmdValid = 1'b0;
      bus.iCmdAddr  = '0;
      bus.iCmdData  = '0;
      bus.iRdValid  = 1'b0;
      bus.iRdAddr   = '0;
      bus.iBusData  = '0;
      step(2);
      chk("reset_cs_n", bus.oChipSelect_n, 1'b1);
      chk("reset_wr_n", bus.oWrite_n, 1'b1);
      chk("reset_rd_n", bus.oRead_n, 1'b1);
      chk("reset_addr", bus.oAddress, 32'h0);
      chk("reset_data", bus.oData, 32'h0);
      chk("reset_rdata", bus.oRdData, 32'h0);
      chk("reset_ready", {bus.oCmdReady, bus.oRdReady, bus.oRdValid, bus.oBusy}, 4'b0);
      iReset_n = 1'b1;
      step(2);

      foreach (tbl[i]) begin
         i0 = wlog.size();
         c = cyc;
         bus.iCmdValid = 1'b1;
         bus.iCmdAddr = tbl[i].addr;
         bus.iCmdData = tbl[i].data;
         step(1);
         bus.iCmdValid = 1'b0;
         step(11);
         chk("tbl_ready_c12", bus.oCmdReady, 1'b0);
         step(1);
         chk("tbl_ready_c13", bus.oCmdReady, 1'b1);
         step(1);
         chk("tbl_count", wlog.size() - i0, 6);
         for (int k = 0; k < 6; k++) begin
            if (i0 + k < wlog.size()) e = wlog[i0 + k];
            else e = '{-1, '1, '1};
            chk("tbl_cycle", e.cyc, c + 1 + 2 * k);
            chk("tbl_offset", e.a, k);
            chk("tbl_word", e.d, tbl[i].exp[k]);
         end
      end

      // Back-to-back: valid held, second command must start exactly 13 cycles later.
      i0 = wlog.size();
      c = cyc;
      bus.iCmdValid = 1'b1;
      bus.iCmdAddr = 5'd1;
      bus.iCmdData = 128'h11111111_22222222_33333333_44444444;
      step(1);
      bus.iCmdAddr = 5'd7;
      bus.iCmdData = 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4;
      step(13);
      bus.iCmdValid = 1'b0;
      step(13);
      chk("b2b_count", wlog.size() - i0, 12);
      chk("b2b_first_trig", first_cyc(wlog, i0 + 5), c + 11);
      chk("b2b_second_start", first_cyc(wlog, i0 + 6), c + 14);
      chk("b2b_second_addr", wlog.size() > i0 + 6 ? wlog[i0 + 6].d : 32'hX, 32'h7);
      chk("b2b_second_d3", wlog.size() > i0 + 10 ? wlog[i0 + 10].d : 32'hX, 32'hD4D4D4D4);

      // Command and read together: write wins, read follows once the master is free.
      r0 = rlog.size();
      c = cyc;
      bus.iBusData = 32'h3C3C0F0F;
      bus.iCmdValid = 1'b1;
      bus.iCmdAddr = 5'd2;
      bus.iCmdData = 128'h01020304_05060708_090A0B0C_0D0E0F10;
      bus.iRdValid = 1'b1;
      bus.iRdAddr = 4'd9;
      #1;
      chk("both_rd_ready", bus.oRdReady, 1'b0);
      chk("both_cmd_ready", bus.oCmdReady, 1'b1);
      step(1);
      bus.iCmdValid = 1'b0;
      step(13);
      bus.iRdValid = 1'b0;
      step(5);
      chk("both_rd_strobe", first_cyc(rlog, r0), RD_EN ? c + 14 : -1);
      chk("both_rd_data", bus.oRdData, RD_EN ? 32'h3C3C0F0F : 32'h0);

      // Single read of offset 2.
      r0 = rlog.size();
      v0 = vlog.size();
      c = cyc;
      bus.iRdValid = 1'b1;
      bus.iRdAddr = 4'd2;
      bus.iBusData = 32'hA5A5A5A5;
      step(1);
      bus.iRdValid = 1'b0;
      step(4);
      chk("rd_strobe_cycle", first_cyc(rlog, r0), RD_EN ? c + 1 : -1);
      chk("rd_strobe_addr", rlog.size() > r0 ? rlog[r0].a : 32'hFFFFFFFF, RD_EN ? 32'h2 : 32'hFFFFFFFF);
      chk("rd_valid_cycle", first_cyc(vlog, v0), RD_EN ? c + 3 : -1);
      chk("rd_captured", bus.oRdData, RD_EN ? 32'hA5A5A5A5 : 32'h0);

      // Reset during the offset-3 strobe: strobes rise at once and no trigger follows.
      i0 = wlog.size();
      c = cyc;
      bus.iCmdValid = 1'b1;
      bus.iCmdAddr = 5'd3;
      bus.iCmdData = 128'hCAFEF00D_0BADBEEF_13579BDF_2468ACE0;
      step(1);
      bus.iCmdValid = 1'b0;
      step(6);
      chk("rst_pre_strobe", bus.oWrite_n, 1'b0);
      iReset_n = 1'b0;
      #1;
      chk("rst_wr_n_now", bus.oWrite_n, 1'b1);
      chk("rst_cs_n_now", bus.oChipSelect_n, 1'b1);
      chk("rst_addr_now", bus.oAddress, 32'h0);
      step(1);
      iReset_n = 1'b1;
      step(2);
      chk("rst_ready_after", bus.oCmdReady, 1'b1);
      chk("rst_busy_after", bus.oBusy, 1'b0);
      step(4);
      chk("rst_write_count", wlog.size() - i0, 3);

      for (int n = 0; n < 1500; n++) begin
         bus.iCmdValid = $urandom_range(0, 3) == 0;
         bus.iCmdAddr  = 5'($urandom);
         bus.iCmdData  = {$urandom, $urandom, $urandom, $urandom};
         bus.iRdValid  = $urandom_range(0, 2) == 0;
         bus.iRdAddr   = 4'($urandom);
         bus.iBusData  = $urandom;
         iReset_n      = $urandom_range(0, 299) != 0;
         step(1);
      end
      bus.iCmdValid = 1'b0;
      bus.iRdValid = 1'b0;
      iReset_n = 1'b1;
      step(20);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
